ex_alu_stage: RTL and testbench
===============================

Name: ex_alu_stage

Overview:
- Execute-stage ALU plus EX/MEM pipeline register, directly downstream of the ALU control decoder.
- Consumes the 5-bit operation code, the two operands, the shift amount and the destination tag.
- Computes the result combinationally and presents it registered to the MEM stage one cycle later.
- Supports stall, flush, and signed-overflow detection.

Parameters:
- DATA_W, 32, operand/result width; the shift and LUI rules below require DATA_W = 32.
- REG_AW, 5, destination register address width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  issue slot holds a real instruction.
- in_op  input  5  operation code from the ALU control decoder.
- in_a  input  DATA_W  rs operand, already forwarded.
- in_b  input  DATA_W  rt operand or sign-extended immediate.
- in_shamt  input  5  instruction shamt field.
- in_rd  input  REG_AW  destination register.
- in_reg_write  input  1  instruction writes the register file.
- stall  input  1  hold the EX/MEM register.
- flush  input  1  squash the instruction being captured.
- out_valid  output  1  registered valid.
- out_result  output  DATA_W  registered ALU result.
- out_zero  output  1  registered (result == 0); consumed by branch resolution.
- out_overflow  output  1  registered signed-overflow flag.
- out_rd  output  REG_AW  registered destination.
- out_reg_write  output  1  registered write enable.

Behaviour:
- Op encoding (result R):
  - 0 AND: a&b. 1 OR: a|b. 2 ADD: a+b. 3 XOR: a^b.
  - 4 SLL: b<<shamt. 5 SRL: b>>shamt (logical). 8 SRA: b>>>shamt.
  - 9 SRLV: b>>a[4:0]. 10 SRAV: b>>>a[4:0]. 11 SLLV: b<<a[4:0].
  - 6 SUB: a-b. 7 SLT: signed a<b ? 1 : 0. 12 NOR: ~(a|b). 13 ADDU: a+b. 14 SUBU: a-b. 15 SLTU: unsigned a<b ? 1 : 0.
  - 16 ADDI: a+b. 17 ADDIU: a+b.
  - 18 ANDI / 19 ORI / 20 XORI: a op {16'b0, b[15:0]} (zero-extended immediate).
  - 21 SLTI: signed compare. 22 SLTIU: unsigned compare of a vs b as supplied.
  - 23 LUI: {b[15:0], 16'b0}.
  - 24–31: R = 0, overflow 0.
- Arithmetic rules:
  - All sums/differences wrap modulo 2^DATA_W.
  - Signed overflow is detected only for ops 2, 6 and 16.
  - Add overflow: a and b have the same sign and the result sign differs.
  - Sub overflow: a and b have different signs and the result sign differs from a.
- Latency: exactly 1 cycle; inputs sampled at a rising edge appear on out_* after that edge.
- Register update per edge, in priority order:
  - reset: all outputs cleared to 0 (out_valid, out_result, out_zero, out_overflow, out_rd, out_reg_write).
  - else flush: out_valid=0, out_reg_write=0, out_overflow=0; out_result/out_rd don't-care, implemented as cleared. Flush overrides stall.
  - else stall: all outputs hold their values.
  - else capture:
    - out_valid = in_valid; out_result = R; out_zero = (R==0); out_rd = in_rd.
    - out_reg_write = in_valid & in_reg_write & ~ovf_effective.
    - out_overflow = in_valid & ovf_effective.
- in_valid=0 capture: out_valid=0, out_reg_write=0, out_overflow=0; result/zero are computed but meaningless.
- No internal state beyond the pipeline register; a reset mid-stall clears everything immediately.
- Shifts by 0 pass b unchanged. SRA/SRAV by 31 yields all copies of b[31].

Optional Feature:
- Macro: EX_OVF_TRAP_EN.
- Defined: ovf_effective = detected overflow. Overflowing ADD/SUB/ADDI suppresses out_reg_write and pulses out_overflow for the exception logic.
- Undefined: ovf_effective = 0. out_overflow is constant 0; ADD/SUB/ADDI behave as ADDU/SUBU/ADDIU, and the write occurs with the wrapped result.

Test Plan:
- ADD: a=0x7FFFFFFF, b=1, valid, reg_write=1 → next cycle:
  - with EX_OVF_TRAP_EN: result 0x80000000, out_overflow=1, out_reg_write=0.
  - without it: out_overflow=0, out_reg_write=1.
- SUB: a=5, b=5 → out_result=0, out_zero=1. SLT: a=0xFFFFFFFF, b=1 → 1. SLTU with the same operands → 0.
- Shifts, b=0x80000010:
  - SRA shamt=4 → 0xF8000001.
  - SRL shamt=4 → 0x08000001.
  - SLLV a=0x24 (uses a[4:0]=4) → 0x00000100.
  - LUI b=0xFFFF1234 → 0x12340000.
  - ORI a=0, b=0xFFFF8000 → 0x00008000.
- Stall: capture ADD 3+4 (result 7), then assert stall 3 cycles while inputs change → outputs hold 7/valid. Deassert → new result next cycle.
- Flush asserted together with stall while a valid write is pending → next cycle out_valid=0, out_reg_write=0.
- Reset asserted with valid input and stall → all outputs 0 after the edge. Op 27 → out_result=0, out_zero=1.

Source files
------------

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with the EX/MEM pipeline register (stall, flush, overflow flag).
// Define EX_OVF_TRAP_EN to let signed overflow on ADD/SUB/ADDI suppress the write and raise out_overflow.
module ex_alu_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [4:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [4:0]        in_shamt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_overflow,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write
);

  localparam int MSB = DATA_W - 1;

  logic signed [DATA_W-1:0] w_aS;
  logic signed [DATA_W-1:0] w_bS;
  logic [DATA_W-1:0]        w_immZext;
  logic [DATA_W-1:0]        w_result;
  logic                     w_ovfEff;

  logic              r_valid;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_overflow;
  logic [REG_AW-1:0] r_rd;
  logic              r_regWrite;

  assign w_aS      = in_a;
  assign w_bS      = in_b;
  assign w_immZext = {{(DATA_W-16){1'b0}}, in_b[15:0]};

  always_comb begin
    w_result = '0;
    case (in_op)
      5'd0:                      w_result = in_a & in_b;
      5'd1:                      w_result = in_a | in_b;
      5'd2, 5'd13, 5'd16, 5'd17: w_result = in_a + in_b;
      5'd3:                      w_result = in_a ^ in_b;
      5'd4:                      w_result = in_b << in_shamt;
      5'd5:                      w_result = in_b >> in_shamt;
      5'd6, 5'd14:               w_result = in_a - in_b;
      5'd7, 5'd21:               w_result = {{(DATA_W-1){1'b0}}, (w_aS < w_bS)};
      5'd8:                      w_result = $unsigned(w_bS >>> in_shamt);
      5'd9:                      w_result = in_b >> in_a[4:0];
      5'd10:                     w_result = $unsigned(w_bS >>> in_a[4:0]);
      5'd11:                     w_result = in_b << in_a[4:0];
      5'd12:                     w_result = ~(in_a | in_b);
      5'd15, 5'd22:              w_result = {{(DATA_W-1){1'b0}}, (in_a < in_b)};
      5'd18:                     w_result = in_a & w_immZext;
      5'd19:                     w_result = in_a | w_immZext;
      5'd20:                     w_result = in_a ^ w_immZext;
      5'd23:                     w_result = {in_b[15:0], {(DATA_W-16){1'b0}}};
      default:                   w_result = '0;
    endcase
  end

`ifdef EX_OVF_TRAP_EN
  // Overflow from sign bits: add needs equal operand signs, sub needs differing ones.
  always_comb begin
    w_ovfEff = 1'b0;
    case (in_op)
      5'd2, 5'd16: w_ovfEff = (in_a[MSB] == in_b[MSB]) && (w_result[MSB] != in_a[MSB]);
      5'd6:        w_ovfEff = (in_a[MSB] != in_b[MSB]) && (w_result[MSB] != in_a[MSB]);
      default:     w_ovfEff = 1'b0;
    endcase
  end
`else
  assign w_ovfEff = 1'b0;
`endif

  // Flush outranks stall so a squashed instruction never lingers in a held register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_rd       <= '0;
      r_regWrite <= 1'b0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_rd       <= '0;
      r_regWrite <= 1'b0;
    end else if (!stall) begin
      r_valid    <= in_valid;
      r_result   <= w_result;
      r_zero     <= (w_result == '0);
      r_overflow <= in_valid & w_ovfEff;
      r_rd       <= in_rd;
      r_regWrite <= in_valid & in_reg_write & ~w_ovfEff;
    end
  end

  assign out_valid     = r_valid;
  assign out_result    = r_result;
  assign out_zero      = r_zero;
  assign out_overflow  = r_overflow;
  assign out_rd        = r_rd;
  assign out_reg_write = r_regWrite;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: arithmetic reference model plus hand-computed vectors.
// Honours EX_OVF_TRAP_EN the same way the design does.
module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic [4:0]  inOp = '0;
  logic [31:0] inA = '0;
  logic [31:0] inB = '0;
  logic [4:0]  inShamt = '0;
  logic [4:0]  inRd = '0;
  logic        inRegWrite = 1'b0;
  logic        inStall = 1'b0;
  logic        inFlush = 1'b0;

  logic        outValid;
  logic [31:0] outResult;
  logic        outZero;
  logic        outOverflow;
  logic [4:0]  outRd;
  logic        outRegWrite;

  int errors = 0;
  int checks = 0;
  logic checkEn = 1'b0;

  logic        expValid = 1'b0;
  logic [31:0] expResult = '0;
  logic        expZero = 1'b0;
  logic        expOverflow = 1'b0;
  logic [4:0]  expRd = '0;
  logic        expRegWrite = 1'b0;

  ex_alu_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk          (clk),
    .reset        (rst),
    .in_valid     (inValid),
    .in_op        (inOp),
    .in_a         (inA),
    .in_b         (inB),
    .in_shamt     (inShamt),
    .in_rd        (inRd),
    .in_reg_write (inRegWrite),
    .stall        (inStall),
    .flush        (inFlush),
    .out_valid    (outValid),
    .out_result   (outResult),
    .out_zero     (outZero),
    .out_overflow (outOverflow),
    .out_rd       (outRd),
    .out_reg_write(outRegWrite)
  );

  always #5 clk = ~clk;

`ifdef EX_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // Reference result, shifts done one bit at a time, immediates via modulo arithmetic.
  function automatic logic [31:0] modelResult(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    int n;
    r = '0;
    n = 0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2, 13, 16, 17: r = a + b;
      3: r = a ^ b;
      4: r = b << sh;
      11: r = b << (a % 32);
      5, 9: begin
        n = (op == 5) ? int'(sh) : int'(a % 32);
        r = b;
        repeat (n) r = r / 2;
      end
      8, 10: begin
        n = (op == 8) ? int'(sh) : int'(a % 32);
        r = b;
        repeat (n) r = {r[31], r[31:1]};
      end
      6, 14: r = a - b;
      7, 21: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      15, 22: r = (a < b) ? 32'd1 : 32'd0;
      12: r = ~(a | b);
      18: r = a & (b % 65536);
      19: r = a | (b % 65536);
      20: r = a ^ (b % 65536);
      23: r = (b % 65536) * 65536;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Overflow means the exact signed result does not fit in 32 bits.
  function automatic logic modelOvf(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = 0;
    case (op)
      2, 16: s = longint'(int'(a)) + longint'(int'(b));
      6:     s = longint'(int'(a)) - longint'(int'(b));
      default: s = 0;
    endcase
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Model of the pipeline register, updated on the same edge as the design.
  always @(posedge clk) begin
    logic ovf;
    ovf = TRAP && modelOvf(inOp, inA, inB);
    if (rst) begin
      expValid <= 0; expResult <= 0; expZero <= 0; expOverflow <= 0; expRd <= 0; expRegWrite <= 0;
    end else if (inFlush) begin
      expValid <= 0; expResult <= 0; expZero <= 0; expOverflow <= 0; expRd <= 0; expRegWrite <= 0;
    end else if (!inStall) begin
      expValid    <= inValid;
      expResult   <= modelResult(inOp, inA, inB, inShamt);
      expZero     <= (modelResult(inOp, inA, inB, inShamt) == 0);
      expRd       <= inRd;
      expOverflow <= inValid && ovf;
      expRegWrite <= inValid && inRegWrite && !ovf;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Model comparison on every falling edge once reset has been applied.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model valid", {31'b0, outValid}, {31'b0, expValid});
      checkOutput("model reg_write", {31'b0, outRegWrite}, {31'b0, expRegWrite});
      checkOutput("model overflow", {31'b0, outOverflow}, {31'b0, expOverflow});
      if (expValid) begin
        checkOutput("model result", outResult, expResult);
        checkOutput("model zero", {31'b0, outZero}, {31'b0, expZero});
        checkOutput("model rd", {27'b0, outRd}, {27'b0, expRd});
      end
    end
  end

  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] sh, input logic [4:0] rd, input logic v,
                               input logic rw, input logic st, input logic fl);
    @(negedge clk);
    inOp = op; inA = a; inB = b; inShamt = sh; inRd = rd;
    inValid = v; inRegWrite = rw; inStall = st; inFlush = fl;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] rd);
    applyStimulus(op, a, b, sh, rd, 1'b1, 1'b1, 1'b0, 1'b0);
    stepCycle();
  endtask

  initial begin
    @(posedge clk);
    checkEn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset valid", {31'b0, outValid}, 32'd0);
    checkOutput("reset result", outResult, 32'd0);
    checkOutput("reset reg_write", {31'b0, outRegWrite}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(5'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd3);
    checkOutput("add ovf result", outResult, 32'h8000_0000);
    checkOutput("add ovf flag", {31'b0, outOverflow}, TRAP ? 32'd1 : 32'd0);
    checkOutput("add ovf reg_write", {31'b0, outRegWrite}, TRAP ? 32'd0 : 32'd1);

    issue(5'd6, 32'd5, 32'd5, 5'd0, 5'd4);
    checkOutput("sub result", outResult, 32'd0);
    checkOutput("sub zero", {31'b0, outZero}, 32'd1);
    issue(5'd7, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd5);
    checkOutput("slt", outResult, 32'd1);
    issue(5'd15, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd5);
    checkOutput("sltu", outResult, 32'd0);
    issue(5'd8, 32'd0, 32'h8000_0010, 5'd4, 5'd6);
    checkOutput("sra 4", outResult, 32'hF800_0001);
    issue(5'd5, 32'd0, 32'h8000_0010, 5'd4, 5'd6);
    checkOutput("srl 4", outResult, 32'h0800_0001);
    issue(5'd11, 32'h24, 32'h8000_0010, 5'd0, 5'd6);
    checkOutput("sllv", outResult, 32'h0000_0100);
    issue(5'd23, 32'd0, 32'hFFFF_1234, 5'd0, 5'd7);
    checkOutput("lui", outResult, 32'h1234_0000);
    issue(5'd19, 32'd0, 32'hFFFF_8000, 5'd0, 5'd7);
    checkOutput("ori", outResult, 32'h0000_8000);
    issue(5'd27, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 5'd8);
    checkOutput("op27 result", outResult, 32'd0);
    checkOutput("op27 zero", {31'b0, outZero}, 32'd1);
    issue(5'd10, 32'd31, 32'h8000_0000, 5'd0, 5'd9);
    checkOutput("srav 31", outResult, 32'hFFFF_FFFF);
    issue(5'd4, 32'd0, 32'hDEAD_BEEF, 5'd0, 5'd9);
    checkOutput("sll 0", outResult, 32'hDEAD_BEEF);

    // Sweep every opcode plus overflow corners through the model.
    for (int op = 0; op < 32; op++) issue(5'(op), 32'h8765_4321, 32'hF0F0_1234, 5'd7, 5'(op));
    issue(5'd6, 32'h8000_0000, 32'd1, 5'd0, 5'd10);
    issue(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 5'd11);
    issue(5'd14, 32'h8000_0000, 32'd1, 5'd0, 5'd12);
    applyStimulus(5'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd13, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("invalid capture valid", {31'b0, outValid}, 32'd0);

    issue(5'd2, 32'd3, 32'd4, 5'd0, 5'd14);
    checkOutput("pre-stall result", outResult, 32'd7);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd3, 32'(i + 100), 32'd55, 5'd0, 5'd15, 1'b1, 1'b1, 1'b1, 1'b0);
      stepCycle();
      checkOutput("stall hold result", outResult, 32'd7);
      checkOutput("stall hold valid", {31'b0, outValid}, 32'd1);
    end
    issue(5'd3, 32'h0000_00F0, 32'h0000_00FF, 5'd0, 5'd16);
    checkOutput("post-stall result", outResult, 32'h0000_000F);

    issue(5'd2, 32'd1, 32'd1, 5'd0, 5'd17);
    applyStimulus(5'd2, 32'd2, 32'd2, 5'd0, 5'd18, 1'b1, 1'b1, 1'b1, 1'b1);
    stepCycle();
    checkOutput("flush valid", {31'b0, outValid}, 32'd0);
    checkOutput("flush reg_write", {31'b0, outRegWrite}, 32'd0);

    issue(5'd1, 32'h00FF_0000, 32'h0000_00FF, 5'd0, 5'd19);
    applyStimulus(5'd2, 32'd9, 32'd9, 5'd0, 5'd20, 1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    stepCycle();
    checkOutput("mid-stall reset valid", {31'b0, outValid}, 32'd0);
    checkOutput("mid-stall reset result", outResult, 32'd0);
    checkOutput("mid-stall reset zero", {31'b0, outZero}, 32'd0);
    checkOutput("mid-stall reset rd", {27'b0, outRd}, 32'd0);
    checkOutput("mid-stall reset reg_write", {31'b0, outRegWrite}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    inStall = 1'b0;
    stepCycle();

    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
